// File: rtl/imemory_stage_pkg.sv
// ----------------------------------------------------------------------------
// imemory_stage_pkg
// Shared types and helpers for the LEGv8 memory-access stage.
//   word_t     : 64-bit datapath word.
//   reg_idx_t  : architectural register number (X0..X31).
//   access_e   : classification of the instruction presented to the stage.
//   memwb_t    : MEM/WB pipeline register contents (except the loaded data,
//                which is registered inside the data memory).
//   is_aligned / in_range : address qualification helpers.
// ----------------------------------------------------------------------------
package imemory_stage_pkg;

    localparam int WORD_BITS    = 64;
    localparam int REG_BITS     = 5;
    localparam int BYTE_OFFSET  = 3;    // 8 bytes per data word

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  reg_idx_t;

    typedef enum logic [1:0] {
        ACC_NONE    = 2'd0,   // no memory access (R-type, branch, bubble)
        ACC_LOAD    = 2'd1,   // legal LDUR
        ACC_STORE   = 2'd2,   // legal STUR
        ACC_ILLEGAL = 2'd3    // misaligned, out of range, or read+write
    } access_e;

    typedef struct packed {
        logic     valid;
        logic     reg_write;
        logic     mem_to_reg;
        reg_idx_t write_reg;
        word_t    alu_result;
    } memwb_t;

    // Data words are 8 bytes; any low-order byte offset is misaligned.
    function automatic logic is_aligned(word_t addr);
        return addr[BYTE_OFFSET-1:0] == '0;
    endfunction

    // In range when nothing above the word-index field is set.
    function automatic logic in_range(word_t addr, int unsigned addr_bits);
        return (addr >> (addr_bits + BYTE_OFFSET)) == '0;
    endfunction

endpackage

// File: rtl/imemory_stage_if.sv
// ----------------------------------------------------------------------------
// imemory_stage_if
// Bundles the execute -> memory inputs and the memory -> fetch/writeback
// outputs of the memory-access stage.
//   master : the upstream side (execute stage / hazard unit / testbench)
//   slave  : the memory-access stage itself
// Inputs to the stage : valid_in, stall, flush, alu_result_in, read_data2_in,
//                       branch_target_in, zero_in, mem_read_in, mem_write_in,
//                       branch_in, uncond_branch_in, mem_to_reg_in,
//                       reg_write_in, write_reg_in
// Outputs of the stage: pc_src, branch_target (combinational), read_data,
//                       alu_result, mem_to_reg, reg_write, write_reg,
//                       valid_out (MEM/WB), mem_error (sticky)
// ----------------------------------------------------------------------------
interface imemory_stage_if;
    import imemory_stage_pkg::*;

    logic     valid_in;
    logic     stall;
    logic     flush;
    word_t    alu_result_in;
    word_t    read_data2_in;
    word_t    branch_target_in;
    logic     zero_in;
    logic     mem_read_in;
    logic     mem_write_in;
    logic     branch_in;
    logic     uncond_branch_in;
    logic     mem_to_reg_in;
    logic     reg_write_in;
    reg_idx_t write_reg_in;

    logic     pc_src;
    word_t    branch_target;
    word_t    read_data;
    word_t    alu_result;
    logic     mem_to_reg;
    logic     reg_write;
    reg_idx_t write_reg;
    logic     valid_out;
    logic     mem_error;

    modport master (
        output valid_in, stall, flush, alu_result_in, read_data2_in,
               branch_target_in, zero_in, mem_read_in, mem_write_in,
               branch_in, uncond_branch_in, mem_to_reg_in, reg_write_in,
               write_reg_in,
        input  pc_src, branch_target, read_data, alu_result, mem_to_reg,
               reg_write, write_reg, valid_out, mem_error
    );

    modport slave (
        input  valid_in, stall, flush, alu_result_in, read_data2_in,
               branch_target_in, zero_in, mem_read_in, mem_write_in,
               branch_in, uncond_branch_in, mem_to_reg_in, reg_write_in,
               write_reg_in,
        output pc_src, branch_target, read_data, alu_result, mem_to_reg,
               reg_write, write_reg, valid_out, mem_error
    );

endinterface

// File: rtl/imemory_stage_idata_memory.sv
// ----------------------------------------------------------------------------
// idata_memory
// DMEM_WORDS x 64-bit data memory with synchronous write, registered read
// and synchronous clear on reset.
//   clk, reset_n : clock, synchronous active-low reset (clears every word)
//   addr         : word index shared by read and write
//   wr_en/wr_data: write the word at addr on the rising edge
//   rd_en        : capture mem[addr] into rd_data; when low, capture 0
//   hold         : keep rd_data unchanged (pipeline stall)
//   rd_data      : registered read data, one cycle after the request
// ----------------------------------------------------------------------------
module idata_memory
    import imemory_stage_pkg::*;
#(
    parameter int DMEM_WORDS = 32,
    parameter int ADDR_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 wr_en,
    input  word_t                wr_data,
    input  logic                 rd_en,
    input  logic                 hold,
    output word_t                rd_data
);

    word_t mem [DMEM_WORDS];

    // NOTE: the array must be cleared on reset, so it is built from
    // resettable flops rather than a RAM macro; a RAM cannot be reset this way.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[addr] <= wr_data;
            end
            // A load and a store never share a cycle, so the read sees the
            // word as left by the previous edge (store-then-load works).
            if (!hold) begin
                rd_data <= rd_en ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: rtl/imemory_stage.sv
// ----------------------------------------------------------------------------
// imemory_stage
// Memory-access stage of the LEGv8 pipeline. Resolves branches back to fetch,
// performs LDUR/STUR against the internal data memory, and holds the MEM/WB
// pipeline register feeding writeback.
//   clk     : system clock, rising edge
//   reset_n : synchronous active-low reset (MEM/WB, mem_error and memory)
//   bus     : imemory_stage_if.slave, execute inputs and stage outputs
// ----------------------------------------------------------------------------
module imemory_stage
    import imemory_stage_pkg::*;
#(
    parameter int DMEM_WORDS = 32,
    parameter int ADDR_BITS  = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    imemory_stage_if.slave    bus
);

    access_e              access;
    logic [ADDR_BITS-1:0] word_idx;
    logic                 mem_wr_en;
    logic                 mem_rd_en;
    memwb_t               memwb_q;
    logic                 mem_error_q;

    // ------------------------------------------------------------------
    // Branch resolution: combinational, deliberately not gated by stall.
    // ------------------------------------------------------------------
    assign bus.pc_src        = bus.valid_in &
                               (bus.uncond_branch_in | (bus.branch_in & bus.zero_in));
    assign bus.branch_target = bus.branch_target_in;

    // ------------------------------------------------------------------
    // Access classification
    // ------------------------------------------------------------------
    assign word_idx = bus.alu_result_in[ADDR_BITS+BYTE_OFFSET-1:BYTE_OFFSET];

    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        access = ACC_NONE;
        if (bus.valid_in && (bus.mem_read_in || bus.mem_write_in)) begin
            if (!is_aligned(bus.alu_result_in) ||
                !in_range(bus.alu_result_in, ADDR_BITS) ||
                (bus.mem_read_in && bus.mem_write_in)) begin
                access = ACC_ILLEGAL;
            end else if (bus.mem_write_in) begin
                access = ACC_STORE;
            end else begin
                access = ACC_LOAD;
            end
        end
    end

    // A stalled store is retried on the first unstalled cycle. Load data is
    // zeroed for bubbles and non-loads so writeback never sees stale data.
    assign mem_wr_en = (access == ACC_STORE) && !bus.stall;
    assign mem_rd_en = (access == ACC_LOAD) && !bus.flush;

    idata_memory #(
        .DMEM_WORDS (DMEM_WORDS),
        .ADDR_BITS  (ADDR_BITS)
    ) u_dmem (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (word_idx),
        .wr_en   (mem_wr_en),
        .wr_data (bus.read_data2_in),
        .rd_en   (mem_rd_en),
        .hold    (bus.stall),
        .rd_data (bus.read_data)
    );

    // ------------------------------------------------------------------
    // MEM/WB register: reset > stall (hold) > flush/invalid (bubble) > capture
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            memwb_q     <= '0;
            mem_error_q <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.flush || !bus.valid_in) begin
                memwb_q <= '0;
            end else begin
                memwb_q.valid      <= 1'b1;
                // A faulting access must not retire a register write.
                memwb_q.reg_write  <= bus.reg_write_in && (access != ACC_ILLEGAL);
                memwb_q.mem_to_reg <= bus.mem_to_reg_in;
                memwb_q.write_reg  <= bus.write_reg_in;
                memwb_q.alu_result <= bus.alu_result_in;
            end
            if (access == ACC_ILLEGAL) begin
                mem_error_q <= 1'b1;
            end
        end
    end

    assign bus.valid_out  = memwb_q.valid;
    assign bus.reg_write  = memwb_q.reg_write;
    assign bus.mem_to_reg = memwb_q.mem_to_reg;
    assign bus.write_reg  = memwb_q.write_reg;
    assign bus.alu_result = memwb_q.alu_result;
    assign bus.mem_error  = mem_error_q;

endmodule

// File: tb/tb_imemory_stage.sv
// ----------------------------------------------------------------------------
// tb_imemory_stage
// Self-checking bench for imemory_stage. Each operation is driven on the
// falling edge; a reference model computes the expected MEM/WB contents and
// pushes them to a scoreboard, which is popped and compared after the next
// rising edge. Branch outputs are compared combinationally before the edge.
// ----------------------------------------------------------------------------
module tb_imemory_stage;
    import imemory_stage_pkg::*;

    logic clk;
    logic reset_n;

    imemory_stage_if bus ();

    imemory_stage #(
        .DMEM_WORDS (32),
        .ADDR_BITS  (5)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       valid;
        bit       stall;
        bit       flush;
        word_t    alu;
        word_t    wdata;
        word_t    target;
        bit       zero;
        bit       mrd;
        bit       mwr;
        bit       br;
        bit       ub;
        bit       m2r;
        bit       rw;
        reg_idx_t wr;
    } op_t;

    typedef struct {
        bit       valid;
        bit       reg_write;
        bit       mem_to_reg;
        reg_idx_t write_reg;
        word_t    alu_result;
        word_t    read_data;
        bit       err;
    } wb_t;

    int    n_checks = 0;
    int    n_errors = 0;
    wb_t   sb[$];
    wb_t   mdl_wb;
    word_t mdl_mem [32];

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- operation builders ----------------
    function automatic op_t op_nop();
        op_t o;
        o = '{default: 0};
        return o;
    endfunction

    function automatic op_t op_stur(word_t addr, word_t data);
        op_t o = op_nop();
        o.valid = 1; o.mwr = 1; o.alu = addr; o.wdata = data;
        return o;
    endfunction

    function automatic op_t op_ldur(word_t addr, reg_idx_t rd);
        op_t o = op_nop();
        o.valid = 1; o.mrd = 1; o.m2r = 1; o.rw = 1; o.alu = addr; o.wr = rd;
        return o;
    endfunction

    function automatic op_t op_rtype(word_t res, reg_idx_t rd);
        op_t o = op_nop();
        o.valid = 1; o.rw = 1; o.alu = res; o.wr = rd;
        return o;
    endfunction

    function automatic op_t op_branch(bit cbz, bit b, bit z, word_t tgt);
        op_t o = op_nop();
        o.valid = 1; o.br = cbz; o.ub = b; o.zero = z; o.target = tgt;
        return o;
    endfunction

    // ---------------- reference model (one rising edge) ----------------
    task automatic model_step(input op_t o);
        bit       acc;
        bit       legal;
        bit [4:0] idx;
        word_t    a;
        a     = o.alu;
        idx   = a[7:3];
        acc   = o.valid && (o.mrd || o.mwr);
        legal = o.valid && (a[2:0] == 3'b000) && ((a >> 8) == 0) && !(o.mrd && o.mwr);
        if (o.rst) begin
            for (int i = 0; i < 32; i++) mdl_mem[i] = '0;
            mdl_wb = '{default: 0};
        end else if (!o.stall) begin
            if (acc && !legal) mdl_wb.err = 1;
            if (o.flush || !o.valid) begin
                mdl_wb.valid = 0; mdl_wb.reg_write = 0; mdl_wb.mem_to_reg = 0;
                mdl_wb.write_reg = '0; mdl_wb.alu_result = '0; mdl_wb.read_data = '0;
            end else begin
                mdl_wb.valid      = 1;
                mdl_wb.reg_write  = o.rw && !(acc && !legal);
                mdl_wb.mem_to_reg = o.m2r;
                mdl_wb.write_reg  = o.wr;
                mdl_wb.alu_result = o.alu;
                mdl_wb.read_data  = (legal && o.mrd) ? mdl_mem[idx] : '0;
            end
            if (legal && o.mwr) mdl_mem[idx] = o.wdata;
        end
        sb.push_back(mdl_wb);
    endtask

    // ---------------- drive one cycle and score it ----------------
    task automatic run_op(input string tag, input op_t o);
        wb_t e;
        @(negedge clk);
        reset_n              = !o.rst;
        bus.valid_in         = o.valid;
        bus.stall            = o.stall;
        bus.flush            = o.flush;
        bus.alu_result_in    = o.alu;
        bus.read_data2_in    = o.wdata;
        bus.branch_target_in = o.target;
        bus.zero_in          = o.zero;
        bus.mem_read_in      = o.mrd;
        bus.mem_write_in     = o.mwr;
        bus.branch_in        = o.br;
        bus.uncond_branch_in = o.ub;
        bus.mem_to_reg_in    = o.m2r;
        bus.reg_write_in     = o.rw;
        bus.write_reg_in     = o.wr;
        #1;
        check({tag, ".pc_src"}, word_t'(bus.pc_src),
              word_t'(o.valid && (o.ub || (o.br && o.zero))));
        check({tag, ".branch_target"}, bus.branch_target, o.target);
        model_step(o);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s.scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".valid_out"},  word_t'(bus.valid_out),  word_t'(e.valid));
            check({tag, ".reg_write"},  word_t'(bus.reg_write),  word_t'(e.reg_write));
            check({tag, ".mem_to_reg"}, word_t'(bus.mem_to_reg), word_t'(e.mem_to_reg));
            check({tag, ".write_reg"},  word_t'(bus.write_reg),  word_t'(e.write_reg));
            check({tag, ".alu_result"}, bus.alu_result,          e.alu_result);
            check({tag, ".read_data"},  bus.read_data,           e.read_data);
            check({tag, ".mem_error"},  word_t'(bus.mem_error),  word_t'(e.err));
        end
    endtask

    initial begin
        op_t o;
        mdl_wb = '{default: 0};
        for (int i = 0; i < 32; i++) mdl_mem[i] = '0;

        // Reset (two cycles), then idle.
        o = op_nop(); o.rst = 1;
        run_op("reset0", o);
        run_op("reset1", o);
        run_op("idle", op_nop());

        // Store then load of the same word in consecutive cycles.
        run_op("stur8", op_stur(64'd8, 64'd520));
        run_op("ldur8", op_ldur(64'd8, 5'd9));

        // Branches.
        run_op("cbz_taken",  op_branch(1, 0, 1, 64'd24));
        run_op("cbz_not",    op_branch(1, 0, 0, 64'd24));
        run_op("b_uncond",   op_branch(0, 1, 0, 64'd100));
        o = op_branch(0, 1, 1, 64'd44); o.valid = 0;
        run_op("b_invalid", o);

        // R-type pass-through.
        run_op("rtype25", op_rtype(64'd25, 5'd3));

        // Stalled store that is never released: memory must stay 0.
        o = op_stur(64'd16, 64'd7); o.stall = 1;
        run_op("stall_st_a", o);
        run_op("stall_st_b", o);
        run_op("ldur16_pre", op_ldur(64'd16, 5'd4));

        // Stalled store held two cycles, then released.
        o = op_stur(64'd16, 64'd7); o.stall = 1;
        run_op("stall_st_c", o);
        run_op("stall_st_d", o);
        o.stall = 0;
        run_op("stur16", o);
        run_op("ldur16", op_ldur(64'd16, 5'd5));

        // Stall and flush together hold; flush alone bubbles.
        o = op_rtype(64'd77, 5'd6); o.stall = 1; o.flush = 1;
        run_op("stall_flush", o);
        o.stall = 0;
        run_op("flush", o);

        // Illegal accesses: misaligned load, out-of-range store, read+write.
        run_op("ldur_misal", op_ldur(64'd12, 5'd7));
        run_op("stur_oor",   op_stur(64'd520, 64'hdead));
        o = op_stur(64'd8, 64'd1); o.mrd = 1;
        run_op("rd_wr_both", o);
        run_op("ldur8_again", op_ldur(64'd8, 5'd8));
        run_op("ldur_top", op_ldur(64'd248, 5'd10));

        // Reset with a store presented: store discarded, everything cleared.
        o = op_stur(64'd8, 64'd99); o.rst = 1;
        run_op("reset_st", o);
        run_op("ldur8_rst", op_ldur(64'd8, 5'd11));

        // Random legal traffic.
        for (int i = 0; i < 60; i++) begin
            word_t addr;
            addr = word_t'($urandom_range(0, 31)) << 3;
            case ($urandom_range(0, 3))
                0: o = op_stur(addr, {$urandom(), $urandom()});
                1: o = op_ldur(addr, 5'($urandom_range(0, 31)));
                2: o = op_rtype({$urandom(), $urandom()}, 5'($urandom_range(0, 31)));
                default: o = op_nop();
            endcase
            o.stall = ($urandom_range(0, 7) == 0);
            o.flush = ($urandom_range(0, 9) == 0);
            run_op("random", o);
        end

        if (sb.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imemory_stage.md
Name: imemory_stage

Overview:
- Memory-access stage of the LEGv8 pipeline, directly downstream of iExecute.
- Consumes the execute results (alu_result, read_data2, branch_target, zero) and the forwarded control bits.
- Resolves branches (pc_src back to fetch), performs LDUR/STUR against an internal 64-bit-word data memory, and holds the MEM/WB pipeline register that feeds writeback.

Parameters:
- DMEM_WORDS, 32, number of 64-bit data memory words; must be a power of two.
- ADDR_BITS, 5, log2(DMEM_WORDS); word-index width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- valid_in  in  1  execute stage presents a valid instruction this cycle.
- stall  in  1  hold the MEM/WB register and suppress memory writes.
- flush  in  1  insert a bubble into MEM/WB.
- alu_result_in  in  `WORD  byte address for D-type; result for R-type.
- read_data2_in  in  `WORD  store data.
- branch_target_in  in  `WORD  computed branch target.
- zero_in  in  1  ALU zero flag.
- mem_read_in  in  1  control: LDUR.
- mem_write_in  in  1  control: STUR.
- branch_in  in  1  control: CBZ.
- uncond_branch_in  in  1  control: B.
- mem_to_reg_in  in  1  control, forwarded.
- reg_write_in  in  1  control, forwarded.
- write_reg_in  in  5  destination register number.
- pc_src  out  1  redirect fetch (combinational).
- branch_target  out  `WORD  equals branch_target_in (combinational).
- read_data  out  `WORD  MEM/WB: loaded data.
- alu_result  out  `WORD  MEM/WB: ALU result.
- mem_to_reg  out  1  MEM/WB control.
- reg_write  out  1  MEM/WB control.
- write_reg  out  5  MEM/WB destination register.
- valid_out  out  1  MEM/WB holds a valid instruction.
- mem_error  out  1  sticky error flag.

Behaviour:
- Reset (reset_n=0 at the clock edge):
  - All MEM/WB outputs and mem_error go to 0.
  - Every data memory word is cleared to 0.
  - Reset overrides stall and flush.
  - A store presented in the same cycle as reset is discarded.
- pc_src = valid_in & (uncond_branch_in | (branch_in & zero_in)). It is purely combinational and is not gated by stall.
- Addressing:
  - word index = alu_result_in[ADDR_BITS+2:3].
  - Misaligned means alu_result_in[2:0] != 0.
  - Out of range means any bit above ADDR_BITS+2 is set.
- Access is legal when valid_in=1, the address is aligned and in range, and mem_read_in and mem_write_in are not both 1.
- Store: when legal, mem_write_in=1 and stall=0, the memory word is written at the rising edge. A stalled store is not written; it is written on the first unstalled cycle.
- Load: synchronous read. read_data is registered from the memory word in the same edge that captures the MEM/WB register, so latency is 1 cycle (the value appears with the instruction in writeback).
- Store-then-load to the same address in consecutive cycles: the load returns the stored value.
- Illegal access (valid_in=1 with mem_read_in or mem_write_in set, and access not legal):
  - No memory write.
  - read_data is captured as 0.
  - reg_write is captured as 0.
  - mem_error is set and stays set until reset.
- MEM/WB update, in priority order:
  - reset.
  - stall: hold all MEM/WB outputs.
  - flush or valid_in=0: bubble, i.e. valid_out=0, reg_write=0, mem_to_reg=0; data fields are don't-care, but the implementation drives 0.
  - otherwise: capture the inputs.
- When stall and flush are both 1, stall wins.
- R-type pass-through: with mem_read_in=0 and mem_write_in=0, read_data is captured as 0 and alu_result carries the result.

Decomposition:
- Use the existing definitions.vh for `WORD, `CYCLE and the opcode/ALUOp macros.
- Add `DMEM_WORDS and the MEM/WB field widths to definitions.vh.
- One sub-module, idata_memory: a DMEM_WORDS x `WORD array with synchronous write, registered read and synchronous clear on reset. The MEM/WB register and branch logic stay in imemory_stage.

Test Plan:
- STUR with alu_result_in=8, read_data2_in=520, valid_in=1, mem_write_in=1; next cycle LDUR with alu_result_in=8, mem_read_in=1, mem_to_reg_in=1 -> one cycle later read_data=520, mem_to_reg=1, valid_out=1.
- CBZ with branch_in=1, zero_in=1, branch_target_in=24 -> pc_src=1 and branch_target=24 in the same cycle. With zero_in=0 -> pc_src=0. B with uncond_branch_in=1 -> pc_src=1 regardless of zero_in.
- R-type with alu_result_in=25, reg_write_in=1, write_reg_in=3 -> next cycle alu_result=25, reg_write=1, write_reg=3, read_data=0.
- Stall held 2 cycles during a STUR to address 16 of value 7 -> MEM/WB outputs unchanged and memory unchanged. After release, the write occurs and a following LDUR of 16 returns 7. With stall=1 and flush=1 together, outputs are held.
- LDUR of alu_result_in=12 (misaligned), then STUR to address 520 (out of range) -> mem_error=1 and stays 1, reg_write=0, and a reload of address 8 still returns its prior value.
- Assert reset_n=0 for one cycle after storing 520 at address 8 -> all outputs 0, mem_error=0, and LDUR of 8 returns 0.
